// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port arbiter onto a single external memory bus, with ready/timeout completion.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*2-1:0]      req_width,
  output logic [NUM_PORTS-1:0]        resp_ready,
  output logic [NUM_PORTS-1:0]        resp_err,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_dout,
  output logic [1:0]                  mem_width,
  output logic                        mem_addr_valid,
  output logic                        mem_dout_write,
  input  logic [DATA_W-1:0]           mem_din,
  input  logic                        mem_din_ready
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] width_q, width_d;
  logic write_q, write_d, err_q, err_d, timed_out;
  logic [CW-1:0] cnt_q, cnt_d;
  // scanning downward leaves the first requester at or after ptr as the winner
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (req_valid[(int'(ptr_q) + i) % NUM_PORTS]) win = PW'((int'(ptr_q) + i) % NUM_PORTS);
  end
  assign timed_out = (TIMEOUT != 0) && (cnt_q >= CW'(TIMEOUT));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = win;
        addr_d  = req_addr[win*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[win*DATA_W +: DATA_W];
        width_d = req_width[win*2 +: 2];
        write_d = req_write[win];
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (mem_din_ready) begin
          rdata_d = mem_din;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (int'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_addr_valid = state_q == BUSY;
  assign mem_dout_write = mem_addr_valid & write_q;
  assign mem_addr       = addr_q;
  assign mem_dout       = wdata_q;
  assign mem_width      = width_q;
  assign resp_rdata     = rdata_q;
  assign resp_ready     = (state_q == DONE) ? NUM_PORTS'(1) << grant_q : '0;
  assign resp_err       = (state_q == DONE && err_q) ? NUM_PORTS'(1) << grant_q : '0;
endmodule
